// File: rtl/adder4bit_ufa.sv
// Registered 4-bit unsigned ripple-carry adder slice, built from full-adder cells
// (two half adders plus an OR); sum and carry-out appear one clock after the operands.

module adder4bit_ufa_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module adder4bit_ufa_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1_s;
    logic c1_s;
    logic c2_s;

    adder4bit_ufa_ha u_ha0 (.a(a),    .b(b),   .s(s1_s), .c(c1_s));
    adder4bit_ufa_ha u_ha1 (.a(s1_s), .b(cin), .s(s),    .c(c2_s));

    assign cout = c1_s | c2_s;
endmodule

module adder4bit_ufa (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] p,
    input  logic [3:0] q,
    output logic [3:0] r,
    output logic       carry
);
    logic [4:0] chain_s;
    logic [3:0] sum_s;
    logic [3:0] r_d;
    logic [3:0] r_q;
    logic       carry_d;
    logic       carry_q;

    // Stage 0 has no carry-in; the carry out of stage 3 becomes the fifth result bit.
    assign chain_s[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_stage
            adder4bit_ufa_fa u_fa (
                .a    (p[i]),
                .b    (q[i]),
                .cin  (chain_s[i]),
                .s    (sum_s[i]),
                .cout (chain_s[i+1])
            );
        end
    endgenerate

    // Next-state of the result registers: the ripple chain output, loaded every cycle.
    always_comb begin
        r_d     = sum_s;
        carry_d = chain_s[4];
    end

    // Result registers, cleared immediately by reset regardless of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= 4'h0;
            carry_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            carry_q <= carry_d;
        end
    end

    assign r     = r_q;
    assign carry = carry_q;
endmodule

// File: tb/tb_adder4bit_ufa.sv
// Directed and exhaustive self-checking bench for the registered 4-bit adder slice.
`timescale 1ns/1ps

module tb_adder4bit_ufa;
    logic       clk;
    logic       rst_n;
    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] r;
    logic       carry;

    int n_vec;
    int n_err;

    adder4bit_ufa dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p     (p),
        .q     (q),
        .r     (r),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, then sample 1 ns after the next rising edge.
    task automatic apply_and_check(input string name, input logic [3:0] pa, input logic [3:0] qa,
                                   input logic [3:0] exp_r, input logic exp_c);
        @(negedge clk);
        p = pa;
        q = qa;
        @(posedge clk);
        #1;
        n_vec++;
        if ({carry, r} !== {exp_c, exp_r}) begin
            n_err++;
            $display("FAIL %s: p=%h q=%h got carry=%b r=%h, want carry=%b r=%h",
                     name, pa, qa, carry, r, exp_c, exp_r);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p = 4'h3;
        q = 4'h4;
        @(posedge clk);
        #1;
        n_vec++;
        if ({carry, r} !== 5'h07) begin
            n_err++;
            $display("FAIL pre_reset_sum: got carry=%b r=%h, want carry=0 r=7", carry, r);
        end
        #1;
        p = 4'hF;
        q = 4'hF;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({carry, r} !== 5'h00) begin
            n_err++;
            $display("FAIL reset_immediate: got carry=%b r=%h, want 0/0", carry, r);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({carry, r} !== 5'h00) begin
                n_err++;
                $display("FAIL reset_hold_%0d: got carry=%b r=%h, want 0/0", k, carry, r);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({carry, r} !== {1'b1, 4'hE}) begin
            n_err++;
            $display("FAIL reset_release: got carry=%b r=%h, want carry=1 r=e", carry, r);
        end
    endtask

    task automatic test_basic();
        apply_and_check("basic_0_0", 4'h0, 4'h0, 4'h0, 1'b0);
        apply_and_check("basic_0_2", 4'h0, 4'h2, 4'h2, 1'b0);
        apply_and_check("basic_9_0", 4'h9, 4'h0, 4'h9, 1'b0);
        apply_and_check("basic_5_a", 4'h5, 4'hA, 4'hF, 1'b0);
    endtask

    task automatic test_overflow();
        apply_and_check("ovf_c_b", 4'hC, 4'hB, 4'h7, 1'b1);
        apply_and_check("ovf_f_1", 4'hF, 4'h1, 4'h0, 1'b1);
        apply_and_check("ovf_f_f", 4'hF, 4'hF, 4'hE, 1'b1);
    endtask

    task automatic test_carry_propagate();
        apply_and_check("prop_f_0", 4'hF, 4'h0, 4'hF, 1'b0);
        // The result must hold until the next rising edge even after the inputs change.
        @(negedge clk);
        p = 4'h8;
        q = 4'h8;
        #3;
        n_vec++;
        if ({carry, r} !== {1'b0, 4'hF}) begin
            n_err++;
            $display("FAIL prop_hold: got carry=%b r=%h, want carry=0 r=f", carry, r);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({carry, r} !== {1'b1, 4'h0}) begin
            n_err++;
            $display("FAIL prop_8_8: got carry=%b r=%h, want carry=1 r=0", carry, r);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] v;
        logic [4:0] exp;
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            @(negedge clk);
            p = v[7:4];
            q = v[3:0];
            exp = {1'b0, v[7:4]} + {1'b0, v[3:0]};
            @(posedge clk);
            #1;
            n_vec++;
            if ({carry, r} !== exp) begin
                n_err++;
                $display("FAIL exhaustive: p=%h q=%h got carry=%b r=%h, want carry=%b r=%h",
                         v[7:4], v[3:0], carry, r, exp[4], exp[3:0]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
        for (int k = 0; k < 6; k++) begin
            a = 4'($urandom_range(15, 0));
            b = 4'($urandom_range(15, 0));
            exp = {1'b0, a} + {1'b0, b};
            @(negedge clk);
            p = a;
            q = b;
            @(posedge clk);
            #1;
            n_vec++;
            if ({carry, r} !== exp) begin
                n_err++;
                $display("FAIL mid_pre: p=%h q=%h got carry=%b r=%h, want %b/%h",
                         a, b, carry, r, exp[4], exp[3:0]);
            end
            // Short low pulse well inside the high half of the clock.
            #1;
            rst_n = 1'b0;
            #1;
            n_vec++;
            if ({carry, r} !== 5'h00) begin
                n_err++;
                $display("FAIL mid_assert: got carry=%b r=%h, want 0/0", carry, r);
            end
            rst_n = 1'b1;
            #1;
            n_vec++;
            if ({carry, r} !== 5'h00) begin
                n_err++;
                $display("FAIL mid_released: got carry=%b r=%h, want 0/0", carry, r);
            end
            a = 4'($urandom_range(15, 0));
            b = 4'($urandom_range(15, 0));
            exp = {1'b0, a} + {1'b0, b};
            @(negedge clk);
            p = a;
            q = b;
            @(posedge clk);
            #1;
            n_vec++;
            if ({carry, r} !== exp) begin
                n_err++;
                $display("FAIL mid_post: p=%h q=%h got carry=%b r=%h, want %b/%h",
                         a, b, carry, r, exp[4], exp[3:0]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        p = 4'h0;
        q = 4'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_carry_propagate();
        test_exhaustive();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
